fmul_iterative: RTL

FMUL_ITERATIVE -- requirements
Module: fmul_iterative

---
 rtl/fmul_iterative_if.sv | 17 +
 rtl/fmul_iterative.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fmul_iterative_if.sv
// Handshake/data bundle for the iterative single-precision multiplier.
//   A, B   : IEEE-754 single-precision operands (master -> slave)
//   start  : request pulse, sampled only while the multiplier is idle
//   busy   : high from the accepted start until done
//   done   : one-cycle pulse marking a valid result
//   result : A*B, held until the next accepted start
interface fmul_iterative_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output A, B, start, input busy, done, result);
  modport slave  (input A, B, start, output busy, done, result);
endinterface

// File: rtl/fmul_iterative.sv
// Iterative IEEE-754 single-precision multiplier (truncating, no denormals).
// A start in IDLE captures the operands; MUL runs 24 shift-add iterations
// (one multiplier bit per cycle, LSB first); NORM normalises, resolves the
// special cases and loads the result. Latency is fixed at 25 cycles.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of fmul_iterative_if (A, B, start, busy, done, result)
module fmul_iterative (
  input  logic               clk,
  input  logic               reset_n,
  fmul_iterative_if.slave    bus
);

  localparam int unsigned SIG_W  = 24;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXP_W  = 10;

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t              state;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [SIG_W-1:0]    mcand;
  logic [SIG_W-1:0]    mplier;
  logic [PROD_W-1:0]   prod;
  logic [CNT_W-1:0]    count;
  logic                busy_q;
  logic                done_q;
  logic [31:0]         result_q;

  logic [SIG_W:0]      add_sum;
  logic [7:0]          exp_a;
  logic [7:0]          exp_b;
  logic                sign;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EXP_W-1:0] exp_fin;
  logic [22:0]         frac;
  logic [31:0]         norm_result;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit is set; the whole product then shifts right by one.
  assign add_sum = {1'b0, prod[PROD_W-1:SIG_W]} + (mplier[0] ? {1'b0, mcand} : (SIG_W+1)'(0));

  // Operand classification, exponent and normalisation of the finished product.
  always_comb begin
    exp_a   = a_q[30:23];
    exp_b   = b_q[30:23];
    sign    = a_q[31] ^ b_q[31];
    a_zero  = (exp_a == 8'h00);
    b_zero  = (exp_b == 8'h00);
    a_inf   = (exp_a == 8'hFF) && (a_q[22:0] == 23'h0);
    b_inf   = (exp_b == 8'hFF) && (b_q[22:0] == 23'h0);
    a_nan   = (exp_a == 8'hFF) && (a_q[22:0] != 23'h0);
    b_nan   = (exp_b == 8'hFF) && (b_q[22:0] != 23'h0);
    exp_fin = $signed(EXP_W'(exp_a) + EXP_W'(exp_b) - EXP_W'(127) + EXP_W'(prod[PROD_W-1]));
    frac    = prod[PROD_W-1] ? prod[46:24] : prod[45:23];

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      norm_result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      norm_result = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      norm_result = {sign, 31'h0};
    end else if (exp_fin >= 10'sd255) begin
      norm_result = {sign, 8'hFF, 23'h0};
    end else if (exp_fin <= 10'sd0) begin
      norm_result = {sign, 31'h0};
    end else begin
      norm_result = {sign, exp_fin[7:0], frac};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            mcand  <= {1'b1, bus.A[22:0]};
            mplier <= {1'b1, bus.B[22:0]};
            prod   <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          prod   <= {add_sum, prod[SIG_W-1:1]};
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(SIG_W - 1)) begin
            state <= NORM;
          end
        end
        NORM: begin
          result_q <= norm_result;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
